// File: rtl/fir_out_packer.sv
// fir_out_packer
//   Output stage of the I/Q decimating FIR. Each strobed 49-bit I/Q result is rounded
//   (round-half-up) to a 24-bit field and registered. The resulting I/Q pair is written
//   into a small FIFO, which drains to the consumer over a valid/ready handshake. The
//   filter is never back-pressured. A pair that arrives while the FIFO is full and not
//   popping is dropped, and the sticky overflow flag is set.
//
//   Build option: define FIR_OUT_SAT_EN to saturate the kept field instead of wrapping it.
//   In that build a clipped sample sets the sticky sat_flag. Without the macro, sat_flag
//   is tied low.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   data_in_I/Q  signed filter outputs, DIN_W bits
//   strobe_in    one-cycle pulse, data_in_I/Q valid
//   data_out_I/Q FIFO head pair, signed DOUT_W bits (hold their value while valid_out=0)
//   valid_out    FIFO non-empty
//   ready_in     consumer accepts the head when valid_out && ready_in
//   level        number of stored pairs, 0..DEPTH
//   overflow     sticky, a pair was dropped
//   sat_flag     sticky, a sample was clipped (saturating build only)
//   clear_flags  synchronous clear of overflow/sat_flag; a same-cycle event wins
module fir_out_packer #(
  parameter int unsigned DIN_W  = 49,
  parameter int unsigned DOUT_W = 24,
  parameter int unsigned SHIFT  = 23,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIN_W-1:0]  data_in_I,
  input  logic [DIN_W-1:0]  data_in_Q,
  input  logic              strobe_in,
  output logic [DOUT_W-1:0] data_out_I,
  output logic [DOUT_W-1:0] data_out_Q,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic              sat_flag,
  input  logic              clear_flags
);

  localparam int unsigned SUM_W    = DIN_W + 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Sign-extend one bit so that adding the rounding constant cannot overflow.
  function automatic logic [SUM_W-1:0] round_sum(input logic [DIN_W-1:0] din);
    round_sum = {din[DIN_W-1], din} + (SUM_W'(1) << (SHIFT - 1));
  endfunction

  function automatic logic [DOUT_W-1:0] round_field(input logic [DIN_W-1:0] din);
    logic [SUM_W-1:0]  sum;
    logic [DOUT_W-1:0] field;
    sum   = round_sum(din);
    field = sum[SHIFT+DOUT_W-1:SHIFT];
`ifdef FIR_OUT_SAT_EN
    // Every bit above the field must match the field MSB; otherwise clip by sign of sum.
    if (sum[SUM_W-1:SHIFT+DOUT_W-1] != {(SUM_W-SHIFT-DOUT_W+1){sum[SHIFT+DOUT_W-1]}}) begin
      field = sum[SUM_W-1] ? {1'b1, {(DOUT_W-1){1'b0}}} : {1'b0, {(DOUT_W-1){1'b1}}};
    end
`endif
    return field;
  endfunction

`ifdef FIR_OUT_SAT_EN
  function automatic logic clips(input logic [DIN_W-1:0] din);
    logic [SUM_W-1:0] sum;
    sum   = round_sum(din);
    clips = (sum[SUM_W-1:SHIFT+DOUT_W-1] !=
             {(SUM_W-SHIFT-DOUT_W+1){sum[SHIFT+DOUT_W-1]}});
  endfunction
`endif

  // Stage 1 registers
  logic [DOUT_W-1:0] stg_i_q, stg_q_q;
  logic              wr_pend_q;

  // FIFO state
  logic [DOUT_W-1:0] mem_i [DEPTH];
  logic [DOUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]       level_q, level_d;
  logic [DOUT_W-1:0] head_i_q, head_i_d, head_q_q, head_q_d;
  logic              overflow_q, overflow_d;

  logic empty, full, pop, push, drop;

  always_comb begin
    empty      = (level_q == '0);
    full       = (level_q == FULL_LVL);
    pop        = !empty && ready_in;
    // When full, a same-cycle pop frees the slot the write lands in.
    push       = wr_pend_q && (!full || pop);
    drop       = wr_pend_q && full && !pop;
    rd_nxt     = rd_ptr_q + AW'(1);
    level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = (overflow_q && !clear_flags) || drop;

    // The head is a registered copy of mem[rd_ptr]. It is only reloaded when the
    // head changes, so it holds its last value while the FIFO is empty.
    head_i_d = head_i_q;
    head_q_d = head_q_q;
    if (pop) begin
      if (level_q > (AW+1)'(1)) begin
        head_i_d = mem_i[rd_nxt];
        head_q_d = mem_q[rd_nxt];
      end else if (push) begin
        head_i_d = stg_i_q;
        head_q_d = stg_q_q;
      end
    end else if (empty && push) begin
      head_i_d = stg_i_q;
      head_q_d = stg_q_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_i_q    <= '0;
      stg_q_q    <= '0;
      wr_pend_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_i_q   <= '0;
      head_q_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_pend_q <= strobe_in;
      if (strobe_in) begin
        stg_i_q <= round_field(data_in_I);
        stg_q_q <= round_field(data_in_Q);
      end
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_nxt;
      level_q    <= level_d;
      head_i_q   <= head_i_d;
      head_q_q   <= head_q_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; only slots below level are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_i[wr_ptr_q] <= stg_i_q;
      mem_q[wr_ptr_q] <= stg_q_q;
    end
  end

`ifdef FIR_OUT_SAT_EN
  logic sat_q, sat_d;

  always_comb begin
    sat_d = (sat_q && !clear_flags) ||
            (strobe_in && (clips(data_in_I) || clips(data_in_Q)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign data_out_I = head_i_q;
  assign data_out_Q = head_q_q;
  assign valid_out  = !empty;
  assign level      = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_out_packer.sv
module tb_fir_out_packer;

`ifdef FIR_OUT_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [48:0] data_in_I, data_in_Q;
  logic        strobe_in;
  logic [23:0] data_out_I, data_out_Q;
  logic        valid_out;
  logic        ready_in;
  logic [4:0]  level;
  logic        overflow;
  logic        sat_flag;
  logic        clear_flags;

  fir_out_packer dut (
    .clk        (clk),
    .reset      (reset),
    .data_in_I  (data_in_I),
    .data_in_Q  (data_in_Q),
    .strobe_in  (strobe_in),
    .data_out_I (data_out_I),
    .data_out_Q (data_out_Q),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .level      (level),
    .overflow   (overflow),
    .sat_flag   (sat_flag),
    .clear_flags(clear_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [47:0] sb[$];
  bit          trk     = 1'b0;
  int          max_lvl = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [48:0] mk(input longint v);
    return v[48:0];
  endfunction

  function automatic logic [23:0] e24(input longint v);
    return v[23:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One strobe; the expected pair is queued only if it should survive.
  task automatic send(input longint i, input longint q, input bit acc,
                      input longint ei, input longint eq);
    data_in_I = mk(i);
    data_in_Q = mk(q);
    strobe_in = 1'b1;
    if (acc) sb.push_back({e24(ei), e24(eq)});
    step();
    strobe_in = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (sb.size() == 0 && !valid_out) break;
      step();
    end
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
    check("drain_valid_low", 64'(valid_out), 64'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid && ready here.
  always @(negedge clk) begin
    if (reset && valid_out && ready_in) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got I=%h Q=%h, required no output",
                 data_out_I, data_out_Q);
      end else begin
        logic [47:0] e;
        e = sb.pop_front();
        check("pop_pair", 64'({data_out_I, data_out_Q}), 64'(e));
      end
    end
    if (trk && int'(level) > max_lvl) max_lvl = int'(level);
  end

  initial begin
    reset = 1'b0; data_in_I = '0; data_in_Q = '0; strobe_in = 1'b0;
    ready_in = 1'b0; clear_flags = 1'b0;

    // 1: reset held with random inputs
    repeat (4) begin
      step();
      data_in_I   = 49'({$urandom(), $urandom()});
      data_in_Q   = 49'({$urandom(), $urandom()});
      strobe_in   = 1'($urandom_range(0, 1));
      ready_in    = 1'($urandom_range(0, 1));
      clear_flags = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_data_I", 64'(data_out_I), 64'd0);
    check("rst_data_Q", 64'(data_out_Q), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    step();
    data_in_I = '0; data_in_Q = '0; strobe_in = 1'b0; ready_in = 1'b0; clear_flags = 1'b0;
    step();
    reset = 1'b1;
    step(); step();
    check("post_rst_valid", 64'(valid_out), 64'd0);
    check("post_rst_level", 64'(level), 64'd0);

    // 2: rounding and two-cycle latency
    ready_in = 1'b1;
    send(64'h80_0000, 64'h40_0000, 1'b1, 1, 1);
    check("lat_n1_valid", 64'(valid_out), 64'd0);
    step();
    check("lat_n2_valid", 64'(valid_out), 64'd1);
    check("lat_n2_data_I", 64'(data_out_I), 64'd1);
    send(64'h3F_FFFF, -(64'sd1 <<< 23), 1'b1, 0, -1);
    send(-(64'sd1 <<< 22), 64'sd3 <<< 22, 1'b1, 0, 2);

    // 3: saturation (or wrap in the default build)
    send(64'sd1 <<< 47, -(64'sd1 <<< 47), 1'b1,
         SatEn ? 64'h7F_FFFF : 64'd0, SatEn ? 64'h80_0000 : 64'd0);
    wait_drain(20);
    check("sat_flag_set", 64'(sat_flag), 64'(SatEn));
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("sat_flag_clr", 64'(sat_flag), 64'd0);

    // 4: overrun with consumer stalled
    ready_in = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      send(longint'(k) <<< 23, -(longint'(k) <<< 23), k <= 16, k, -k);
    end
    step(); step();
    check("ovr_level", 64'(level), 64'd16);
    check("ovr_flag", 64'(overflow), 64'd1);
    check("ovr_valid", 64'(valid_out), 64'd1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    check("ovr_clr", 64'(overflow), 64'd0);

    // 5: write into a full FIFO during a pop
    send(64'sd100 <<< 23, 64'sd7 <<< 23, 1'b1, 100, 7);
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    check("full_pp_level", 64'(level), 64'd16);
    check("full_pp_ovr", 64'(overflow), 64'd0);
    ready_in = 1'b1;
    wait_drain(40);
    check("full_pp_drained", 64'(level), 64'd0);

    // 6: back-to-back strobes with a free-running consumer
    max_lvl = 0;
    trk = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send((longint'(k) <<< 23) | 64'h3F_FFFF, (longint'(k) <<< 23) + (64'sd1 <<< 22),
           1'b1, k, k + 1);
    end
    wait_drain(20);
    trk = 1'b0;
    check("b2b_level_le2", 64'(max_lvl <= 2), 64'd1);
    check("b2b_no_ovr", 64'(overflow), 64'd0);

    // Mid-stream reset discards stored pairs
    ready_in = 1'b0;
    for (int k = 0; k < 5; k++) send(longint'(k) <<< 23, 0, 1'b1, k, 0);
    step(); step();
    check("mid_level", 64'(level), 64'd5);
    check("mid_valid", 64'(valid_out), 64'd1);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_valid", 64'(valid_out), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    step();
    reset = 1'b1;
    step();
    ready_in = 1'b1;
    send(64'sd3 <<< 23, 64'sd4 <<< 23, 1'b1, 3, 4);
    wait_drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
